// File: rtl/serv_dbg_pkg.sv
// Shared encodings for the debug-mode sequencer: FSM states and dcsr.cause values.
package serv_dbg_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_PEND,
        ST_HALTED,
        ST_EXEC,
        ST_RESUME,
        ST_STEP
    } dbg_state_e;

    localparam logic [2:0] CAUSE_NONE      = 3'd0;
    localparam logic [2:0] CAUSE_EBREAK    = 3'd1;
    localparam logic [2:0] CAUSE_HALTREQ   = 3'd3;
    localparam logic [2:0] CAUSE_STEP      = 3'd4;
    localparam logic [2:0] CAUSE_RESETHALT = 3'd5;

    // Debug entry only pulses dpc when the core was running normal code.
    function automatic logic enters_from_code(dbg_state_e s);
        return (s == ST_RUN) || (s == ST_PEND) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/serv_dbg_timer.sv
// Down counter that bounds how long a DM-injected instruction may run.
module serv_dbg_timer #(
    parameter int W = 6
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '1;
        end else if (en_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Flags the cycle in which the count steps down onto zero.
    assign zero_o = en_i && !load_i && (cnt_d == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serv_dbg_ctrl.sv
// Debug-mode sequencer: halt/resume handshake, single-step and injected-instruction
// execution for the bit-serial core. All outputs come straight from flops.
module serv_dbg_ctrl
    import serv_dbg_pkg::*;
#(
    parameter bit RESET_HALT = 1'b0,
    parameter int EXEC_TO_W  = 6
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_haltreq,
    input  logic       i_resumereq,
    input  logic       i_exec,
    input  logic       i_insn_done,
    input  logic       i_ebreak,
    input  logic       i_dret,
    input  logic       i_step,
    output logic       o_stall,
    output logic       o_halted,
    output logic       o_resumeack,
    output logic       o_dpc_wen,
    output logic       o_dbg_halt,
    output logic [2:0] o_cause,
    output logic       o_exec_err
);

    dbg_state_e state_q, state_d;
    logic [2:0] cause_q, cause_d;
    logic       execErr_q, execErr_d;
    logic       stall_q, halted_q, resumeAck_q, dpcWen_q, dbgHalt_q;
    logic       timerLoad, timerEn, timerZero;

    serv_dbg_timer #(
        .W(EXEC_TO_W)
    ) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .load_i (timerLoad),
        .en_i   (timerEn),
        .zero_o (timerZero)
    );

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        execErr_d = execErr_q;
        timerLoad = 1'b0;
        timerEn   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (i_insn_done && i_ebreak) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_EBREAK;
                end else if (i_haltreq) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (i_insn_done) begin
                    state_d = ST_HALTED;
                    cause_d = i_ebreak ? CAUSE_EBREAK : CAUSE_HALTREQ;
                end
            end
            ST_STEP: begin
                if (i_insn_done) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_STEP;
                end
            end
            ST_HALTED: begin
                if (i_resumereq) begin
                    state_d = ST_RESUME;
                end else if (i_exec) begin
                    state_d   = ST_EXEC;
                    execErr_d = 1'b0;
                    timerLoad = 1'b1;
                end
            end
            ST_EXEC: begin
                timerEn = 1'b1;
                // A retirement in the expiry cycle counts as success.
                if (i_insn_done && i_dret) begin
                    state_d = ST_RESUME;
                end else if (i_insn_done) begin
                    state_d = ST_HALTED;
                end else if (timerZero) begin
                    state_d   = ST_HALTED;
                    execErr_d = 1'b1;
                end
            end
            ST_RESUME: begin
                state_d = i_step ? ST_STEP : ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= RESET_HALT ? ST_HALTED : ST_RUN;
            cause_q     <= RESET_HALT ? CAUSE_RESETHALT : CAUSE_NONE;
            execErr_q   <= 1'b0;
            stall_q     <= RESET_HALT;
            halted_q    <= RESET_HALT;
            resumeAck_q <= 1'b0;
            dpcWen_q    <= 1'b0;
            dbgHalt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            execErr_q   <= execErr_d;
            stall_q     <= (state_d == ST_HALTED) || (state_d == ST_RESUME);
            halted_q    <= (state_d == ST_HALTED) || (state_d == ST_EXEC);
            resumeAck_q <= (state_d == ST_RESUME);
            dpcWen_q    <= (state_d == ST_HALTED) && enters_from_code(state_q);
            dbgHalt_q   <= ((state_d == ST_HALTED) || (state_d == ST_EXEC))
                           && (cause_d == CAUSE_HALTREQ);
        end
    end

    assign o_stall     = stall_q;
    assign o_halted    = halted_q;
    assign o_resumeack = resumeAck_q;
    assign o_dpc_wen   = dpcWen_q;
    assign o_dbg_halt  = dbgHalt_q;
    assign o_cause     = cause_q;
    assign o_exec_err  = execErr_q;

endmodule

// File: tb/tb_serv_dbg_ctrl.sv
// Directed bench for serv_dbg_ctrl; observed vector is
// {stall, halted, resumeack, dpc_wen, dbg_halt, exec_err, cause[2:0]}.
module tb_serv_dbg_ctrl;

    logic       clk;
    logic       rst;
    logic       haltreq, resumereq, exec, insnDone, ebreak, dret, step;
    logic       stall0, halted0, ack0, dpc0, dbg0, err0;
    logic [2:0] cause0;
    logic       stall1, halted1, ack1, dpc1, dbg1, err1;
    logic [2:0] cause1;
    logic [8:0] obs, obsRh;
    int         checks;
    int         errors;

    serv_dbg_ctrl #(.RESET_HALT(1'b0), .EXEC_TO_W(6)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_haltreq(haltreq), .i_resumereq(resumereq),
        .i_exec(exec), .i_insn_done(insnDone), .i_ebreak(ebreak), .i_dret(dret),
        .i_step(step), .o_stall(stall0), .o_halted(halted0), .o_resumeack(ack0),
        .o_dpc_wen(dpc0), .o_dbg_halt(dbg0), .o_cause(cause0), .o_exec_err(err0)
    );

    serv_dbg_ctrl #(.RESET_HALT(1'b1), .EXEC_TO_W(6)) u_dutRh (
        .i_clk(clk), .i_rst(rst), .i_haltreq(haltreq), .i_resumereq(resumereq),
        .i_exec(exec), .i_insn_done(insnDone), .i_ebreak(ebreak), .i_dret(dret),
        .i_step(step), .o_stall(stall1), .o_halted(halted1), .o_resumeack(ack1),
        .o_dpc_wen(dpc1), .o_dbg_halt(dbg1), .o_cause(cause1), .o_exec_err(err1)
    );

    assign obs   = {stall0, halted0, ack0, dpc0, dbg0, err0, cause0};
    assign obsRh = {stall1, halted1, ack1, dpc1, dbg1, err1, cause1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== 9'b0_0_0_0_0_0_000) begin
            errors++;
            $display("[TB] FAIL reset_run: got %b expected %b", obs, 9'b0_0_0_0_0_0_000);
        end
        checks++;
        if (obsRh !== 9'b1_1_0_0_0_0_101) begin
            errors++;
            $display("[TB] FAIL reset_halt: got %b expected %b", obsRh, 9'b1_1_0_0_0_0_101);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obsRh !== 9'b1_1_0_0_0_0_101) begin
            errors++;
            $display("[TB] FAIL reset_halt_release: got %b expected %b", obsRh, 9'b1_1_0_0_0_0_101);
        end
    endtask

    task automatic test_halt();
        haltreq = 1'b1;
        tick();
        checks++;
        if (obs !== 9'b0_0_0_0_0_0_000) begin
            errors++;
            $display("[TB] FAIL halt_pend: got %b expected %b", obs, 9'b0_0_0_0_0_0_000);
        end
        repeat (4) tick();
        insnDone = 1'b1;
        tick();
        insnDone = 1'b0;
        checks++;
        if (obs !== 9'b1_1_0_1_1_0_011) begin
            errors++;
            $display("[TB] FAIL halt_entry: got %b expected %b", obs, 9'b1_1_0_1_1_0_011);
        end
        haltreq = 1'b0;
        tick();
        checks++;
        if (obs !== 9'b1_1_0_0_1_0_011) begin
            errors++;
            $display("[TB] FAIL halt_dpc_once: got %b expected %b", obs, 9'b1_1_0_0_1_0_011);
        end
    endtask

    task automatic test_resume();
        resumereq = 1'b1;
        tick();
        checks++;
        if (obs !== 9'b1_0_1_0_0_0_011) begin
            errors++;
            $display("[TB] FAIL resume_ack: got %b expected %b", obs, 9'b1_0_1_0_0_0_011);
        end
        resumereq = 1'b0;
        tick();
        checks++;
        if (obs !== 9'b0_0_0_0_0_0_011) begin
            errors++;
            $display("[TB] FAIL resume_run: got %b expected %b", obs, 9'b0_0_0_0_0_0_011);
        end
    endtask

    task automatic test_ebreak();
        haltreq  = 1'b1;
        insnDone = 1'b1;
        ebreak   = 1'b1;
        tick();
        haltreq  = 1'b0;
        insnDone = 1'b0;
        ebreak   = 1'b0;
        checks++;
        if (obs !== 9'b1_1_0_1_0_0_001) begin
            errors++;
            $display("[TB] FAIL ebreak_entry: got %b expected %b", obs, 9'b1_1_0_1_0_0_001);
        end
        resumereq = 1'b1;
        tick();
        resumereq = 1'b0;
        tick();
        checks++;
        if (obs !== 9'b0_0_0_0_0_0_001) begin
            errors++;
            $display("[TB] FAIL ebreak_resume: got %b expected %b", obs, 9'b0_0_0_0_0_0_001);
        end
    endtask

    task automatic test_step();
        haltreq = 1'b1;
        tick();
        haltreq  = 1'b0;
        insnDone = 1'b1;
        tick();
        insnDone = 1'b0;
        tick();
        step      = 1'b1;
        resumereq = 1'b1;
        tick();
        checks++;
        if (obs !== 9'b1_0_1_0_0_0_011) begin
            errors++;
            $display("[TB] FAIL step_ack: got %b expected %b", obs, 9'b1_0_1_0_0_0_011);
        end
        resumereq = 1'b0;
        tick();
        checks++;
        if (obs !== 9'b0_0_0_0_0_0_011) begin
            errors++;
            $display("[TB] FAIL step_running: got %b expected %b", obs, 9'b0_0_0_0_0_0_011);
        end
        haltreq = 1'b1;
        tick();
        checks++;
        if (obs !== 9'b0_0_0_0_0_0_011) begin
            errors++;
            $display("[TB] FAIL step_ignores_haltreq: got %b expected %b", obs, 9'b0_0_0_0_0_0_011);
        end
        step     = 1'b0;
        insnDone = 1'b1;
        ebreak   = 1'b1;
        tick();
        haltreq  = 1'b0;
        insnDone = 1'b0;
        ebreak   = 1'b0;
        checks++;
        if (obs !== 9'b1_1_0_1_0_0_100) begin
            errors++;
            $display("[TB] FAIL step_entry: got %b expected %b", obs, 9'b1_1_0_1_0_0_100);
        end
        tick();
    endtask

    task automatic test_exec();
        exec = 1'b1;
        tick();
        exec = 1'b0;
        checks++;
        if (obs !== 9'b0_1_0_0_0_0_100) begin
            errors++;
            $display("[TB] FAIL exec_enter: got %b expected %b", obs, 9'b0_1_0_0_0_0_100);
        end
        tick();
        tick();
        insnDone = 1'b1;
        tick();
        insnDone = 1'b0;
        checks++;
        if (obs !== 9'b1_1_0_0_0_0_100) begin
            errors++;
            $display("[TB] FAIL exec_done: got %b expected %b", obs, 9'b1_1_0_0_0_0_100);
        end
        tick();
    endtask

    task automatic test_exec_timeout();
        exec = 1'b1;
        tick();
        exec = 1'b0;
        repeat (62) tick();
        checks++;
        if (obs !== 9'b0_1_0_0_0_0_100) begin
            errors++;
            $display("[TB] FAIL timeout_not_yet: got %b expected %b", obs, 9'b0_1_0_0_0_0_100);
        end
        tick();
        checks++;
        if (obs !== 9'b1_1_0_0_0_1_100) begin
            errors++;
            $display("[TB] FAIL timeout_err: got %b expected %b", obs, 9'b1_1_0_0_0_1_100);
        end
        tick();
        checks++;
        if (obs !== 9'b1_1_0_0_0_1_100) begin
            errors++;
            $display("[TB] FAIL timeout_sticky: got %b expected %b", obs, 9'b1_1_0_0_0_1_100);
        end
        exec = 1'b1;
        tick();
        exec = 1'b0;
        checks++;
        if (obs !== 9'b0_1_0_0_0_0_100) begin
            errors++;
            $display("[TB] FAIL timeout_clear: got %b expected %b", obs, 9'b0_1_0_0_0_0_100);
        end
        insnDone = 1'b1;
        tick();
        insnDone = 1'b0;
        // Retirement lands exactly in the expiry cycle: success, no error.
        exec = 1'b1;
        tick();
        exec = 1'b0;
        repeat (62) tick();
        insnDone = 1'b1;
        tick();
        insnDone = 1'b0;
        checks++;
        if (obs !== 9'b1_1_0_0_0_0_100) begin
            errors++;
            $display("[TB] FAIL timeout_done_wins: got %b expected %b", obs, 9'b1_1_0_0_0_0_100);
        end
        tick();
    endtask

    task automatic test_exec_dret();
        exec = 1'b1;
        tick();
        exec     = 1'b0;
        insnDone = 1'b1;
        dret     = 1'b1;
        tick();
        insnDone = 1'b0;
        dret     = 1'b0;
        checks++;
        if (obs !== 9'b1_0_1_0_0_0_100) begin
            errors++;
            $display("[TB] FAIL dret_ack: got %b expected %b", obs, 9'b1_0_1_0_0_0_100);
        end
        tick();
        checks++;
        if (obs !== 9'b0_0_0_0_0_0_100) begin
            errors++;
            $display("[TB] FAIL dret_run: got %b expected %b", obs, 9'b0_0_0_0_0_0_100);
        end
    endtask

    task automatic test_back_to_back();
        haltreq = 1'b1;
        tick();
        insnDone = 1'b1;
        tick();
        insnDone = 1'b0;
        checks++;
        if (obs !== 9'b1_1_0_1_1_0_011) begin
            errors++;
            $display("[TB] FAIL collide_halt: got %b expected %b", obs, 9'b1_1_0_1_1_0_011);
        end
        resumereq = 1'b1;
        tick();
        checks++;
        if (obs !== 9'b1_0_1_0_0_0_011) begin
            errors++;
            $display("[TB] FAIL collide_resume_wins: got %b expected %b", obs, 9'b1_0_1_0_0_0_011);
        end
        resumereq = 1'b0;
        tick();
        tick();
        checks++;
        if (obs !== 9'b0_0_0_0_0_0_011) begin
            errors++;
            $display("[TB] FAIL collide_pend: got %b expected %b", obs, 9'b0_0_0_0_0_0_011);
        end
        insnDone = 1'b1;
        tick();
        insnDone = 1'b0;
        haltreq  = 1'b0;
        checks++;
        if (obs !== 9'b1_1_0_1_1_0_011) begin
            errors++;
            $display("[TB] FAIL collide_rehalt: got %b expected %b", obs, 9'b1_1_0_1_1_0_011);
        end
        tick();
    endtask

    task automatic test_reset_mid_exec();
        exec = 1'b1;
        tick();
        exec = 1'b0;
        checks++;
        if (obs !== 9'b0_1_0_0_1_0_011) begin
            errors++;
            $display("[TB] FAIL midexec_enter: got %b expected %b", obs, 9'b0_1_0_0_1_0_011);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (obs !== 9'b0_0_0_0_0_0_000) begin
            errors++;
            $display("[TB] FAIL midexec_reset: got %b expected %b", obs, 9'b0_0_0_0_0_0_000);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== 9'b0_0_0_0_0_0_000) begin
            errors++;
            $display("[TB] FAIL midexec_after: got %b expected %b", obs, 9'b0_0_0_0_0_0_000);
        end
        checks++;
        if (obsRh !== 9'b1_1_0_0_0_0_101) begin
            errors++;
            $display("[TB] FAIL midexec_resethalt: got %b expected %b", obsRh, 9'b1_1_0_0_0_0_101);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        haltreq   = 1'b0;
        resumereq = 1'b0;
        exec      = 1'b0;
        insnDone  = 1'b0;
        ebreak    = 1'b0;
        dret      = 1'b0;
        step      = 1'b0;
        @(negedge clk);
        test_reset();
        test_halt();
        test_resume();
        test_ebreak();
        test_step();
        test_exec();
        test_exec_timeout();
        test_exec_dret();
        test_back_to_back();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serv_dbg_ctrl.md
# serv_dbg_ctrl

Debug-mode sequencer for the bit-serial core. It owns the halt/resume handshake with the external debug module (DM) and stalls fetch at instruction boundaries. It drives single-step from `dcsr.step` and runs DM-injected instructions one at a time under a timeout. Its outputs are `o_dbg_halt`, `o_dpc_wen` and `o_cause`: the CSR unit uses them to build `dcsr.cause` and to capture `dpc`, and the fetch/decode path uses `o_stall`.

## Interface
Parameters:
- `RESET_HALT`, default 0: 1 = leave reset in HALTED with cause 5 (resethaltreq).
- `EXEC_TO_W`, default 6: width of the injected-instruction timeout counter; timeout = 2^EXEC_TO_W − 1 cycles.

Ports (reset `i_rst`, synchronous, active-high; clock `i_clk`):
- `i_clk`  in  1  clock
- `i_rst`  in  1  synchronous active-high reset
- `i_haltreq`  in  1  DM halt request, level
- `i_resumereq`  in  1  DM resume request, level
- `i_exec`  in  1  DM pulse: run one injected instruction
- `i_insn_done`  in  1  one-cycle pulse; core retired an instruction (last `cnt_done`)
- `i_ebreak`  in  1  retiring instruction is ebreak; qualified by `i_insn_done`
- `i_dret`  in  1  retiring instruction is dret; qualified by `i_insn_done`
- `i_step`  in  1  `dcsr.step` from the CSR unit
- `o_stall`  out  1  hold fetch; core must not start a new instruction
- `o_halted`  out  1  core is in debug mode awaiting the DM
- `o_resumeack`  out  1  one-cycle resume acknowledge
- `o_dpc_wen`  out  1  one-cycle pulse: capture next PC into `dpc`
- `o_dbg_halt`  out  1  debug entry caused by haltreq; feeds CSR cause logic
- `o_cause`  out  3  `dcsr.cause`: 1 ebreak, 3 haltreq, 4 step, 5 resethaltreq
- `o_exec_err`  out  1  sticky: injected instruction timed out

## Operation
- States: RUN, PEND, HALTED, EXEC, RESUME, STEP. All outputs are registered.
- RUN, stall 0:
  - `i_insn_done & i_ebreak` → HALTED, cause 1.
  - Otherwise `i_haltreq` → PEND.
- PEND, stall 0: on `i_insn_done` → HALTED, cause 1 if `i_ebreak`, else 3.
- STEP, stall 0: `i_haltreq` is ignored. On `i_insn_done` → HALTED, cause 4; step outranks ebreak and haltreq.
- HALTED, stall 1, halted 1, priority order:
  - `i_resumereq` → RESUME.
  - `i_exec` → EXEC: clear `o_exec_err`, load the timer.
  - `i_haltreq` has no effect.
- EXEC, stall 0, halted 1:
  - `i_insn_done & i_dret` → RESUME.
  - `i_insn_done` → HALTED.
  - Timer reaches 0 → HALTED, set `o_exec_err`.
  - EXEC never pulses `o_dpc_wen` and never changes cause.
- RESUME, stall 1:
  - Lasts one cycle with `o_resumeack` = 1.
  - Next state is STEP if `i_step`, else RUN.
  - Cause holds its value until the next entry.
- `o_dpc_wen` = 1 in exactly the first cycle of HALTED when it is entered from RUN, PEND or STEP.
- `o_dbg_halt` = (state ∈ {HALTED, EXEC}) & cause == 3.
- Reset:
  - RESET_HALT=0: state RUN; all outputs 0; cause 0.
  - RESET_HALT=1: state HALTED; `o_stall` and `o_halted` = 1; cause 5; `o_dpc_wen` 0.
  - Reset mid-EXEC or mid-PEND abandons the operation; no ack or dpc pulse follows.

## Timing
- Stall asserts the cycle after the `i_insn_done` that triggers entry. The PC already holds the next instruction address, which is why `o_dpc_wen` lands in that same cycle.
- Halt latency from `i_haltreq` is one cycle to PEND, then however long the current instruction takes to finish.
- Resume: the cycle after `i_resumereq` is sampled high in HALTED, `o_resumeack` = 1 and `o_halted` = 0. Stall drops one cycle later.
  - The DM deasserts `i_resumereq` after the ack.
  - A `i_resumereq` still high on return to RUN is ignored; it is sampled only in HALTED.
- `i_haltreq` and `i_resumereq` both high in HALTED: resume wins. RUN then sees haltreq and goes to PEND.
- Timer: loaded to all-ones on EXEC entry, decrements every EXEC cycle. `i_insn_done` in the same cycle the timer hits 0 wins, and no error is flagged.
- Step with `i_step` deasserted while in STEP: the current step still completes and halts.

## Structure
- `serv_dbg_pkg` holds the state encoding and the cause constants (`CAUSE_EBREAK`=1, `CAUSE_HALTREQ`=3, `CAUSE_STEP`=4, `CAUSE_RESETHALT`=5).
- Sub-module `serv_dbg_timer`: EXEC_TO_W-bit down counter with load, enable and zero flag.

## Test plan
- Halt: RUN, `i_haltreq`=1, `i_insn_done` 5 cycles later → one-cycle `o_dpc_wen`, `o_halted`=1, `o_cause`=3, `o_dbg_halt`=1, `o_stall`=1 from the next cycle.
- ebreak: in RUN, `i_insn_done & i_ebreak` with `i_haltreq`=1 → cause 1, `o_dbg_halt`=0.
- Step: resume with `i_step`=1 → `o_resumeack` one cycle, STEP. The next `i_insn_done` (with `i_ebreak`=1) → cause 4 and a `o_dpc_wen` pulse.
- Injected instruction:
  - `i_exec`, then `i_insn_done` → back to HALTED, no `o_dpc_wen`.
  - `i_exec` with no done for 63 cycles (W=6) → `o_exec_err`=1. A later `i_exec` clears it.
  - `i_exec`, then `i_insn_done & i_dret` → RESUME ack.
- Collision: `i_haltreq` and `i_resumereq` both high in HALTED → resumeack, then PEND; halts again at the next `i_insn_done` with cause 3.
- Reset: RESET_HALT=1 → HALTED, cause 5, no `o_dpc_wen`. `i_rst` mid-EXEC → RUN (RESET_HALT=0), all outputs 0.
